// File: rtl/trace_pkt_gate.sv
// Trace packet gate: delays each packet until its keep/drop decision arrives,
// queues kept packets in a fall-through FIFO and streams them as AXI-Stream bursts.
module trace_pkt_gate #(
    parameter int DATA_WIDTH     = 1024,
    parameter int FILTER_LATENCY = 2,
    parameter int FIFO_DEPTH     = 16,
    parameter int BURST_LEN      = 8,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              pkt_valid,
    input  logic [DATA_WIDTH-1:0]             pkt_data,
    input  logic                              keep_pkt,
    input  logic                              flush,
    input  logic                              clear_counters,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic [CNT_WIDTH-1:0]              kept_count,
    output logic [CNT_WIDTH-1:0]              dropped_count,
    output logic [CNT_WIDTH-1:0]              overflow_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [FILTER_LATENCY-1:0] r_dl_vld;
    logic [DATA_WIDTH-1:0]     r_dl_data [FILTER_LATENCY];
    logic [DATA_WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [LW-1:0]             r_wr_ptr;
    logic [LW-1:0]             r_rd_ptr;
    logic [BW-1:0]             r_beat;
    logic                      r_flush_pend;
    logic [CNT_WIDTH-1:0]      r_kept;
    logic [CNT_WIDTH-1:0]      r_dropped;
    logic [CNT_WIDTH-1:0]      r_overflow;

    logic [LW-1:0] w_level;
    logic          w_empty;
    logic          w_tvalid;
    logic          w_tlast;
    logic          w_rd;
    logic          w_dec;
    logic          w_space;
    logic          w_wr;
    logic          w_ovf;
    logic          w_drop;

    // Delay line: valids are control and reset, the payload is not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dl_vld <= '0;
        end else begin
            r_dl_vld[0] <= pkt_valid;
            for (int i = 1; i < FILTER_LATENCY; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_dl_data[0] <= pkt_data;
        for (int i = 1; i < FILTER_LATENCY; i++) begin
            r_dl_data[i] <= r_dl_data[i-1];
        end
    end

    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_level == '0);
    assign w_tvalid = !w_empty;
    assign w_rd     = w_tvalid && m_axis_tready;
    assign w_tlast  = w_tvalid &&
                      ((r_beat == BEAT_LAST) || (r_flush_pend && (w_level == LW'(1))));

    // A full FIFO still accepts a packet when the head leaves in the same cycle
    assign w_dec   = r_dl_vld[FILTER_LATENCY-1] && en;
    assign w_space = (w_level < DEPTH_L) || w_rd;
    assign w_wr    = w_dec && keep_pkt && w_space;
    assign w_ovf   = w_dec && keep_pkt && !w_space;
    assign w_drop  = w_dec && !keep_pkt;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_dl_data[FILTER_LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + LW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + LW'(1);
                r_beat   <= w_tlast ? '0 : r_beat + BW'(1);
            end
            if (flush) begin
                r_flush_pend <= 1'b1;
            end else if ((w_rd && w_tlast) || w_empty) begin
                r_flush_pend <= 1'b0;
            end
        end
    end

    // Statistics: clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kept     <= '0;
            r_dropped  <= '0;
            r_overflow <= '0;
        end else if (clear_counters) begin
            r_kept     <= '0;
            r_dropped  <= '0;
            r_overflow <= '0;
        end else begin
            if (w_wr) begin
                r_kept <= sat_inc(r_kept);
            end
            if (w_drop) begin
                r_dropped <= sat_inc(r_dropped);
            end
            if (w_ovf) begin
                r_overflow <= sat_inc(r_overflow);
            end
        end
    end

    assign m_axis_tdata   = w_tvalid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    assign m_axis_tvalid  = w_tvalid;
    assign m_axis_tlast   = w_tlast;
    assign fifo_level     = w_level;
    assign kept_count     = r_kept;
    assign dropped_count  = r_dropped;
    assign overflow_count = r_overflow;

endmodule

// File: tb/tb_trace_pkt_gate.sv
// Directed bench for trace_pkt_gate: pass-through, overflow, full-with-read,
// bursts/flush, enable/clear and asynchronous reset.
module tb_trace_pkt_gate;

    localparam int DW = 32;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          pkt_valid;
    logic [DW-1:0] pkt_data;
    logic          keep_pkt;
    logic          flush;
    logic          clear_counters;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [4:0]    fifo_level;
    logic [31:0]   kept_count;
    logic [31:0]   dropped_count;
    logic [31:0]   overflow_count;

    int n_chk = 0;
    int n_bad = 0;
    int first_vld;
    int lvl_hist [64];
    logic [DW-1:0] q_data [$];
    bit            q_last [$];

    trace_pkt_gate #(
        .DATA_WIDTH(DW), .FILTER_LATENCY(L), .FIFO_DEPTH(16), .BURST_LEN(8), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .keep_pkt(keep_pkt), .flush(flush), .clear_counters(clear_counters),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .fifo_level(fifo_level), .kept_count(kept_count),
        .dropped_count(dropped_count), .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    // Beats are recorded half a cycle ahead of the edge that transfers them
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pkt_valid = 1'b0; keep_pkt = 1'b0; flush = 1'b0; clear_counters = 1'b0;
        m_axis_tready = 1'b0; en = 1'b1; pkt_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        q_data.delete();
        q_last.delete();
    endtask

    // Packet i carries base+i; its keep bit is driven L cycles after it is presented
    task automatic send(input int n, input logic [31:0] mask, input int base,
                        input int rdy_at, input int clr_at);
        first_vld = -1;
        for (int c = 0; c < n + L; c++) begin
            pkt_valid      = (c < n);
            pkt_data       = DW'(base + c);
            keep_pkt       = (c >= L && c - L < n) ? mask[c-L] : 1'b0;
            m_axis_tready  = (c >= rdy_at);
            clear_counters = (c == clr_at);
            lvl_hist[c]    = int'(fifo_level);
            if (first_vld < 0 && m_axis_tvalid) first_vld = c;
            tick();
        end
        pkt_valid = 1'b0; keep_pkt = 1'b0; clear_counters = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        m_axis_tready = 1'b1;
        while ((fifo_level != 0) && k < 100) begin
            tick();
            k++;
        end
        tick();
        chk(tag, fifo_level, 0);
    endtask

    initial begin
        int exp_t1 [6];
        bit in_order;
        logic [15:0] lmask;
        exp_t1 = '{0, 2, 3, 6, 8, 9};

        do_reset();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_kept", kept_count, 0);
        chk("rst_dropped", dropped_count, 0);
        chk("rst_ovf", overflow_count, 0);

        // Basic pass-through
        send(10, 32'b1101001101, 0, 0, -1);
        drain("t1_drain");
        chk("t1_first_vld", first_vld, 3);
        chk("t1_nbeats", q_data.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t1_beat%0d", i), q_data[i], exp_t1[i]);
        chk("t1_kept", kept_count, 6);
        chk("t1_dropped", dropped_count, 4);

        // Overflow
        do_reset();
        send(20, 32'hFFFFF, 100, 999, -1);
        chk("t2_level", fifo_level, 16);
        chk("t2_ovf", overflow_count, 4);
        chk("t2_kept", kept_count, 16);
        chk("t2_head", m_axis_tdata, 100);
        drain("t2_drain");
        chk("t2_nbeats", q_data.size(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("t2_beat%0d", i), q_data[i], 100 + i);

        // Full with simultaneous read
        do_reset();
        send(24, 32'hFFFFFF, 200, L + 16, -1);
        chk("t3_lvl_a", lvl_hist[L+16], 16);
        chk("t3_lvl_b", lvl_hist[L+20], 16);
        chk("t3_lvl_end", fifo_level, 16);
        chk("t3_ovf", overflow_count, 0);
        chk("t3_kept", kept_count, 24);
        drain("t3_drain");
        chk("t3_nbeats", q_data.size(), 24);
        in_order = 1'b1;
        for (int i = 0; i < q_data.size(); i++) if (q_data[i] != DW'(200 + i)) in_order = 1'b0;
        chk("t3_order", in_order, 1);

        // Bursts and flush
        do_reset();
        send(11, 32'h7FF, 400, 999, -1);
        begin
            int k;
            k = 0;
            m_axis_tready = 1'b1;
            while (fifo_level != 3 && k < 50) begin
                tick();
                k++;
            end
            m_axis_tready = 1'b0;
        end
        chk("t4_lvl3", fifo_level, 3);
        chk("t4_tlast_pre", m_axis_tlast, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t4_tlast_pend", m_axis_tlast, 0);
        drain("t4_drain");
        chk("t4_nbeats", q_data.size(), 11);
        lmask = '0;
        for (int i = 0; i < q_last.size() && i < 16; i++) if (q_last[i]) lmask[i] = 1'b1;
        chk("t4_tlast_map", lmask, 16'h0480);
        flush = 1'b1; tick(); flush = 1'b0;
        tick(); tick();
        chk("t4_empty_flush_vld", m_axis_tvalid, 0);
        chk("t4_empty_flush_beats", q_data.size(), 11);
        send(1, 32'h1, 430, 999, -1);
        chk("t4_after_vld", m_axis_tvalid, 1);
        chk("t4_after_tlast", m_axis_tlast, 0);
        drain("t4_drain2");

        // Enable and clear
        do_reset();
        send(2, 32'h1, 500, 0, -1);
        drain("t5_drain1");
        en = 1'b0;
        send(5, 32'h1F, 510, 0, -1);
        drain("t5_drain2");
        en = 1'b1;
        chk("t5_nbeats", q_data.size(), 1);
        chk("t5_kept", kept_count, 1);
        chk("t5_dropped", dropped_count, 1);
        chk("t5_ovf", overflow_count, 0);
        send(1, 32'h1, 520, 999, L);
        chk("t5_clr_kept", kept_count, 0);
        chk("t5_clr_dropped", dropped_count, 0);
        chk("t5_clr_level", fifo_level, 1);
        drain("t5_drain3");

        // Asynchronous reset mid-operation
        do_reset();
        send(5, 32'h1F, 600, 999, -1);
        chk("t6_pre_vld", m_axis_tvalid, 1);
        chk("t6_pre_level", fifo_level, 5);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_vld", m_axis_tvalid, 0);
        chk("t6_async_level", fifo_level, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        m_axis_tready = 1'b1;
        repeat (5) tick();
        chk("t6_beats", q_data.size(), 0);
        chk("t6_vld", m_axis_tvalid, 0);
        chk("t6_kept", kept_count, 0);
        chk("t6_ovf", overflow_count, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

endmodule
